// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory arbiter
package mem_pkg;

  localparam int NUM_PORTS      = 2;
  localparam int CTRL_WIDTH     = 3;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

  // Access size/sign codes, shared with the data controller.
  localparam logic [CTRL_WIDTH-1:0] CTRL_BYTE   = 3'b000;
  localparam logic [CTRL_WIDTH-1:0] CTRL_HALF   = 3'b001;
  localparam logic [CTRL_WIDTH-1:0] CTRL_WORD   = 3'b010;
  localparam logic [CTRL_WIDTH-1:0] CTRL_BYTE_U = 3'b100;
  localparam logic [CTRL_WIDTH-1:0] CTRL_HALF_U = 3'b101;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic                      we;
  } mem_req_t;

  // Response slot occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - two-input round-robin / fixed-priority grant selection
//
// Ports:
//   valid      - request present, one bit per port
//   last_grant - index of the port granted most recently
//   grant      - one-hot grant (all zero when nothing is valid)
module rr_picker
  import mem_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 last_grant,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    if (FIXED_PRIORITY) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      // Contention goes to the port that did not win last time.
      if (&valid) grant = last_grant ? 2'b01 : 2'b10;
      else        grant = valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of the data memory unit
//
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   req_valid_i/req_ready_o   - per-port request handshake (ready = grant)
//   req_addr_i/wdata/ctrl/we  - per-port request payload
//   rsp_valid_o/rsp_ready_i   - per-port response handshake
//   rsp_rdata_o               - per-port load data (0 for store acks)
//   mem_*_o                   - granted payload towards the memory unit
//   mem_readData_i            - combinational read data from the memory unit
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NUM_PORTS-1:0]                    req_valid_i,
  output logic [NUM_PORTS-1:0]                    req_ready_o,
  input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_PORTS-1:0][CTRL_WIDTH-1:0]    req_ctrl_i,
  input  logic [NUM_PORTS-1:0]                    req_we_i,
  output logic [NUM_PORTS-1:0]                    rsp_valid_o,
  input  logic [NUM_PORTS-1:0]                    rsp_ready_i,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    rsp_rdata_o,
  output logic [ADDRESS_WIDTH-1:0]                mem_address_o,
  output logic [DATA_WIDTH-1:0]                   mem_writeData_o,
  output logic [CTRL_WIDTH-1:0]                   mem_dataMemControl_o,
  output logic                                    mem_writeEnable_o,
  input  logic [DATA_WIDTH-1:0]                   mem_readData_i
);

  slot_state_t           state_q, state_d;
  logic                  owner_q;
  logic                  last_grant_q;
  logic [DATA_WIDTH-1:0] slot_data_q;

  logic                  slot_valid;
  logic                  drain;
  logic                  slot_free;
  logic [NUM_PORTS-1:0]  pick;
  logic                  any_grant;
  logic                  gnt_idx;

  assign slot_valid = (state_q == ST_FULL);
  assign drain      = slot_valid && rsp_ready_i[owner_q];
  // A draining slot can be refilled in the same cycle, giving 1 txn/cycle.
  assign slot_free  = !slot_valid || drain;

  rr_picker #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_picker (
    .valid     (req_valid_i),
    .last_grant(last_grant_q),
    .grant     (pick)
  );

  // Gating on rst_i keeps any store from reaching memory during reset.
  assign req_ready_o = (slot_free && !rst_i) ? pick : '0;
  assign any_grant   = |req_ready_o;
  assign gnt_idx     = req_ready_o[1];

  always_comb begin
    mem_address_o        = '0;
    mem_writeData_o      = '0;
    mem_dataMemControl_o = '0;
    mem_writeEnable_o    = 1'b0;
    if (any_grant) begin
      mem_address_o        = req_addr_i[gnt_idx];
      mem_writeData_o      = req_wdata_i[gnt_idx];
      mem_dataMemControl_o = req_ctrl_i[gnt_idx];
      mem_writeEnable_o    = req_we_i[gnt_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (any_grant) state_d = ST_FULL;
      ST_FULL:  if (!any_grant && drain) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      slot_data_q  <= '0;
    end else if (any_grant) begin
      owner_q      <= gnt_idx;
      last_grant_q <= gnt_idx;
      slot_data_q  <= req_we_i[gnt_idx] ? '0 : mem_readData_i;
    end
  end

  always_comb begin
    rsp_valid_o          = '0;
    rsp_rdata_o          = '0;
    rsp_valid_o[owner_q] = slot_valid;
    rsp_rdata_o[owner_q] = slot_data_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_valid = '0;
  logic [1:0]        rsp_ready = '0;
  mem_req_t          req [2];
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0][2:0]   req_ctrl;
  logic [1:0]        req_we;

  logic [1:0]        req_ready, rsp_valid;
  logic [1:0][31:0]  rsp_rdata;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [2:0]        mem_ctrl;
  logic              mem_we;

  logic [1:0]        fp_req_ready, fp_rsp_valid;
  logic [1:0][31:0]  fp_rsp_rdata;
  logic [31:0]       fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic [2:0]        fp_mem_ctrl;
  logic              fp_mem_we;

  logic [31:0]       mem [64];
  logic [31:0]       q0[$], q1[$];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_addr[p]  = req[p].addr;
      req_wdata[p] = req[p].wdata;
      req_ctrl[p]  = req[p].ctrl;
      req_we[p]    = req[p].we;
    end
  end

  assign mem_rdata    = mem[mem_addr[7:2]];
  assign fp_mem_rdata = mem[fp_mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .FIXED_PRIORITY(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ctrl_i(req_ctrl), .req_we_i(req_we),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .mem_address_o(mem_addr), .mem_writeData_o(mem_wdata),
    .mem_dataMemControl_o(mem_ctrl), .mem_writeEnable_o(mem_we),
    .mem_readData_i(mem_rdata)
  );

  mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(fp_req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ctrl_i(req_ctrl), .req_we_i(req_we),
    .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(fp_rsp_rdata),
    .mem_address_o(fp_mem_addr), .mem_writeData_o(fp_mem_wdata),
    .mem_dataMemControl_o(fp_mem_ctrl), .mem_writeEnable_o(fp_mem_we),
    .mem_readData_i(fp_mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] c, input logic w);
    req[p] = '{addr: a, wdata: d, ctrl: c, we: w};
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  // Drive one cycle's handshake inputs, check the grant, and queue the
  // responses the bench expects from any grant it predicts.
  task automatic step(input logic r, input logic [1:0] v, input logic [1:0] rr,
                      input logic [1:0] exp_rdy, input logic exp_we, input logic push,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic chk_fp, input logic [1:0] exp_fp, input string nm);
    rst       = r;
    req_valid = v;
    rsp_ready = rr;
    #1;
    chk({nm, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({nm, "_we"}, 32'(mem_we), 32'(exp_we));
    if (chk_fp) chk({nm, "_fp_ready"}, 32'(fp_req_ready), 32'(exp_fp));
    if (push && exp_rdy[0]) q0.push_back(e0);
    if (push && exp_rdy[1]) q1.push_back(e1);
  endtask

  // Monitor: every response handshake must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (rsp_valid == 2'b11) chk("rsp_onehot", 32'(rsp_valid), 32'h1);
        if (rsp_valid == 2'b01) chk("rsp_lane1_zero", rsp_rdata[1], 32'h0);
        if (rsp_valid == 2'b10) chk("rsp_lane0_zero", rsp_rdata[0], 32'h0);
        if (rsp_valid[0] && rsp_ready[0]) begin
          if (q0.size() == 0) chk("rsp0_unexpected", 32'h1, 32'h0);
          else chk("rsp0_data", rsp_rdata[0], q0.pop_front());
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
          if (q1.size() == 0) chk("rsp1_unexpected", 32'h1, 32'h0);
          else chk("rsp1_data", rsp_rdata[1], q1.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[4] = 32'hDEAD_BEEF;
    set_req(0, 32'h30, 32'h0000_0BAD, CTRL_WORD, 1'b1);
    set_req(1, 32'h04, 32'h0, CTRL_WORD, 1'b0);
    adv();

    // Reset with a store presented: nothing granted, nothing written.
    step(1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, "rst1"); adv();
    step(1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, "rst2"); adv();
    step(0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, "post_rst");
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rdata0", rsp_rdata[0], 32'h0);
    chk("reset_rdata1", rsp_rdata[1], 32'h0);
    chk("reset_no_store", mem[12], 32'hA000_000C);
    adv();

    // Single load from port 0, response one cycle later.
    set_req(0, 32'h10, 32'h0, CTRL_WORD, 1'b0);
    step(0, 2'b01, 2'b11, 2'b01, 0, 1, 32'hDEAD_BEEF, 0, 1, 2'b01, "load0");
    chk("load0_addr", mem_addr, 32'h10);
    adv();
    step(0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, "load0_idle");
    chk("load0_latency_valid", 32'(rsp_valid), 32'h1);
    chk("load0_latency_data", rsp_rdata[0], 32'hDEAD_BEEF);
    adv();

    // Contention: round robin alternates, fixed priority always picks port 0.
    set_req(0, 32'h00, 32'h0, CTRL_WORD, 1'b0);
    set_req(1, 32'h04, 32'h0, CTRL_WORD, 1'b0);
    step(0, 2'b11, 2'b11, 2'b10, 0, 1, 32'hA000_0000, 32'hA000_0001, 1, 2'b01, "rr_a"); adv();
    step(0, 2'b11, 2'b11, 2'b01, 0, 1, 32'hA000_0000, 32'hA000_0001, 1, 2'b01, "rr_b"); adv();
    step(0, 2'b11, 2'b11, 2'b10, 0, 1, 32'hA000_0000, 32'hA000_0001, 1, 2'b01, "rr_c"); adv();
    step(0, 2'b11, 2'b11, 2'b01, 0, 1, 32'hA000_0000, 32'hA000_0001, 1, 2'b01, "rr_d"); adv();
    step(0, 2'b10, 2'b11, 2'b10, 0, 1, 0, 32'hA000_0001, 1, 2'b10, "fp_p1_after"); adv();

    // Port 1 store: write enable only in the grant cycle, zero ack data.
    set_req(1, 32'h20, 32'h1234_5678, CTRL_WORD, 1'b1);
    step(0, 2'b10, 2'b11, 2'b10, 1, 1, 0, 32'h0, 0, 2'b00, "store1");
    chk("store1_addr", mem_addr, 32'h20);
    chk("store1_wdata", mem_wdata, 32'h1234_5678);
    chk("store1_ctrl", 32'(mem_ctrl), 32'(CTRL_WORD));
    adv();
    step(0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, "store1_idle");
    chk("store1_ack_valid", 32'(rsp_valid), 32'h2);
    chk("store1_ack_data", rsp_rdata[1], 32'h0);
    adv();
    set_req(0, 32'h20, 32'h0, CTRL_WORD, 1'b0);
    step(0, 2'b01, 2'b11, 2'b01, 0, 1, 32'h1234_5678, 0, 0, 2'b00, "readback"); adv();

    // Backpressure on port 0 blocks port 1 until the response is taken.
    set_req(0, 32'h10, 32'h0, CTRL_WORD, 1'b0);
    set_req(1, 32'h04, 32'h0, CTRL_WORD, 1'b0);
    step(0, 2'b01, 2'b11, 2'b01, 0, 1, 32'hDEAD_BEEF, 0, 0, 2'b00, "bp_load"); adv();
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, "bp_hold");
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_data", rsp_rdata[0], 32'hDEAD_BEEF);
      adv();
    end
    step(0, 2'b10, 2'b01, 2'b10, 0, 1, 0, 32'hA000_0001, 0, 2'b00, "bp_release"); adv();
    step(0, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00, "bp_drain"); adv();

    // Reset while a response is pending and a store is presented.
    set_req(0, 32'h00, 32'h0, CTRL_WORD, 1'b0);
    step(0, 2'b01, 2'b11, 2'b01, 0, 0, 0, 0, 0, 2'b00, "mid_load"); adv();
    set_req(0, 32'h30, 32'h0000_0BAD, CTRL_WORD, 1'b1);
    set_req(1, 32'h04, 32'h0, CTRL_WORD, 1'b0);
    step(1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2'b00, "mid_rst"); adv();
    step(0, 2'b11, 2'b11, 2'b01, 1, 1, 32'h0, 0, 1, 2'b01, "after_rst");
    chk("mid_rst_dropped", 32'(rsp_valid), 32'h0);
    chk("mid_rst_no_store", mem[12], 32'hA000_000C);
    adv();
    step(0, 2'b10, 2'b11, 2'b10, 0, 1, 0, 32'hA000_0001, 0, 2'b00, "after_rst_p1"); adv();
    chk("after_rst_store", mem[12], 32'h0000_0BAD);
    step(0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, "tail1"); adv();
    step(0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, "tail2"); adv();
    adv();

    chk("q0_empty", 32'(q0.size()), 32'h0);
    chk("q1_empty", 32'(q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the data memory unit: the CPU load/store port (port 0) and a debug/loader port (port 1).
- Selects one request per cycle and drives the memory unit's address, write data, 3-bit access control and write enable.
- Registers the returned read data into a one-entry response slot per transaction, so each requester sees a valid/ready request and response handshake with fixed 1-cycle latency.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDRESS_WIDTH, 32, byte address width.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  [1:0]  request present, one bit per port.
- req_ready_o  out  [1:0]  request accepted (grant) this cycle.
- req_addr_i  in  [1:0][ADDRESS_WIDTH-1:0]  byte address.
- req_wdata_i  in  [1:0][DATA_WIDTH-1:0]  store data.
- req_ctrl_i  in  [1:0][2:0]  access size/sign code, passed through unchanged.
- req_we_i  in  [1:0]  1 = store, 0 = load.
- rsp_valid_o  out  [1:0]  response available.
- rsp_ready_i  in  [1:0]  requester accepts response.
- rsp_rdata_o  out  [1:0][DATA_WIDTH-1:0]  load data; 0 for stores.
- mem_address_o  out  ADDRESS_WIDTH  to memory unit.
- mem_writeData_o  out  DATA_WIDTH  to memory unit.
- mem_dataMemControl_o  out  3  to memory unit.
- mem_writeEnable_o  out  1  to memory unit.
- mem_readData_i  in  DATA_WIDTH  combinational read data from memory unit.

Behaviour:
- Reset (rst_i=1 at an edge): rsp_valid_o=0, both rsp_rdata registers=0, owner=0, last_grant=1. While rst_i is high, req_ready_o=0 and mem_writeEnable_o=0 combinationally, so no store reaches memory during reset. Reset mid-transaction drops any pending response silently.
- Slot free = !slot_valid OR (rsp_ready_i[owner] AND rsp_valid_o[owner]). This allows back-to-back throughput of 1 transaction per cycle.
- Grant (combinational), only when slot free and not in reset:
  - FIXED_PRIORITY=1: lowest-index valid port wins.
  - FIXED_PRIORITY=0: if both ports are valid, grant the port != last_grant; otherwise grant the single valid port.
- req_ready_o has exactly one bit set when any grant is made; otherwise both bits are 0. A requester holds valid and all payload stable until ready.
- Downstream outputs: mem_* mirror the granted port's payload. mem_writeEnable_o = granted AND req_we_i[granted]. With no grant: address/data/control = 0 and we = 0.
- On the granting edge:
  - slot_valid <= 1, owner <= granted port, last_grant <= granted port.
  - Slot data <= mem_readData_i for a load, or 0 for a store.
  - The store is committed to memory by the same edge.
- Latency: response is visible the cycle after grant. rsp_valid_o[owner] = slot_valid; the other bit is 0. rsp_rdata_o[owner] = slot data; the non-owner lane reads 0.
- Backpressure: while rsp_valid_o is high and rsp_ready_i[owner]=0, the slot holds its value and no new grants occur.
- Drain: handshake without a new grant clears slot_valid.
- Simultaneous drain and new grant: the slot is reloaded and stays valid, with no bubble.
- Stores also produce a response (write acknowledge), so every request completes exactly once and in order per port.
- Address alignment and sub-word handling belong to the memory unit; the arbiter never alters the address or the control code.
- FSM is implicit in two states: EMPTY (slot_valid=0) and FULL (slot_valid=1), with the transitions above.

Decomposition:
- Shared package mem_pkg:
  - typedef mem_req_t {addr, wdata, ctrl[2:0], we}.
  - Constants NUM_PORTS=2 and the 3-bit control encodings (byte, half, word, byte-unsigned, half-unsigned), shared with the data controller.
- One natural sub-module, rr_picker: 2-input round-robin/fixed-priority grant logic taking valid, last_grant and FIXED_PRIORITY, and returning a one-hot grant.

Test Plan:
- Reset, then port 0 loads addr 0x10 with mem=0xDEADBEEF -> req_ready_o=01 at cycle 0; rsp_valid_o=01 and rsp_rdata_o[0]=0xDEADBEEF at cycle 1.
- Both ports request continuously with rsp_ready_i=11, FIXED_PRIORITY=0 -> grants alternate 01,10,01,10 with one response per cycle and no bubbles.
- Same stimulus with FIXED_PRIORITY=1 -> port 0 granted every cycle; port 1 ready stays 0 until port 0 deasserts.
- Port 1 stores 0x12345678 to 0x20 (ctrl=word) -> mem_writeEnable_o=1 only in the grant cycle; rsp_valid_o=10 next cycle with rdata 0; a subsequent port 0 load of 0x20 returns 0x12345678.
- Port 0 load completes with rsp_ready_i[0]=0 for 3 cycles while port 1 requests -> rsp held constant; req_ready_o=00 for those 3 cycles; port 1 is granted in the cycle rsp_ready_i[0] rises.
- rst_i asserted while a response is pending and port 0 is presenting a store -> mem_writeEnable_o=0, rsp_valid_o=00 after the edge; after release, port 0 is granted first.
